// File: rtl/frame_write_ctrl.sv
// rtl/frame_write_ctrl.sv - FIFO-to-DDR burst write scheduler with triple frame buffer rotation
// Define FRAME_WR_STAT_EN to add the frame_words and burst_cnt statistics outputs.
module frame_write_ctrl #(
  parameter int          MEM_DATA_BITS = 32,
  parameter int          BURST_LEN     = 64,
  parameter logic [23:0] BASE_ADDR     = 24'h000000,
  parameter logic [23:0] FRAME_SIZE    = 24'h040000
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [1:0]               rd_lock_idx,
  input  logic [10:0]              fifo_rd_count,
  output logic                     fifo_rd_en,
  input  logic [MEM_DATA_BITS-1:0] fifo_rd_data,
  output logic                     wr_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [23:0]              wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish,
  output logic [1:0]               wr_frame_idx,
  output logic [1:0]               done_frame_idx,
  output logic                     frame_done,
  output logic                     frame_overrun
`ifdef FRAME_WR_STAT_EN
  ,
  output logic [23:0]              frame_words,
  output logic [15:0]              burst_cnt
`endif
);

  localparam logic [10:0] BURST_CNT_THR = 11'(BURST_LEN);
  localparam logic [9:0]  BURST_LEN_W   = 10'(BURST_LEN);
  localparam logic [23:0] BUF1_ADDR     = BASE_ADDR + FRAME_SIZE;
  localparam logic [23:0] BUF2_ADDR     = BASE_ADDR + FRAME_SIZE + FRAME_SIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_REQ,
    S_BURST,
    S_SWAP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        load_req;
  logic [9:0]  len_nxt;
  logic        last_nxt;
  logic        last_burst;
  logic        pend_start;
  logic [23:0] offset;
  logic [23:0] frame_base;
  logic [23:0] off_sum;
  logic [24:0] off_end;
  logic [1:0]  swap_idx;

  always_ff @(posedge mem_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_req  = 1'b0;
    len_nxt   = BURST_LEN_W;
    last_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_start) begin
          state_nxt = S_FLUSH;
        end else if (fifo_rd_count >= BURST_CNT_THR) begin
          load_req  = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_FLUSH: begin
        if (fifo_rd_count == 11'd0) begin
          state_nxt = S_SWAP;
        end else if (fifo_rd_count < BURST_CNT_THR) begin
          load_req  = 1'b1;
          len_nxt   = fifo_rd_count[9:0];
          last_nxt  = 1'b1;
          state_nxt = S_REQ;
        end else begin
          load_req  = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ:   if (wr_burst_data_req) state_nxt = S_BURST;
      S_BURST: if (wr_burst_finish) state_nxt = last_burst ? S_SWAP : S_IDLE;
      S_SWAP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The controller may ask for the first word while req is still up, so pops are allowed in REQ too.
  assign wr_burst_req  = (state == S_REQ);
  assign fifo_rd_en    = wr_burst_data_req && ((state == S_REQ) || (state == S_BURST));
  assign wr_burst_data = fifo_rd_data;

  always_comb begin
    case (wr_frame_idx)
      2'd1:    frame_base = BUF1_ADDR;
      2'd2:    frame_base = BUF2_ADDR;
      default: frame_base = BASE_ADDR;
    endcase
  end

  // Pick the buffer that is neither the one just written nor the one the reader holds.
  always_comb begin
    if ((rd_lock_idx == wr_frame_idx) || (rd_lock_idx == 2'd3))
      swap_idx = (wr_frame_idx == 2'd2) ? 2'd0 : wr_frame_idx + 2'd1;
    else
      swap_idx = 2'd3 - wr_frame_idx - rd_lock_idx;
  end

  assign off_sum = offset + {14'd0, wr_burst_len};
  assign off_end = {1'b0, off_sum} + {15'd0, wr_burst_len};

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      wr_burst_len   <= 10'd0;
      wr_burst_addr  <= BASE_ADDR;
      last_burst     <= 1'b0;
      pend_start     <= 1'b0;
      offset         <= 24'd0;
      wr_frame_idx   <= 2'd0;
      done_frame_idx <= 2'd2;
      frame_done     <= 1'b0;
      frame_overrun  <= 1'b0;
    end else begin
      frame_done <= (state == S_SWAP);
      if (load_req) begin
        wr_burst_len  <= len_nxt;
        wr_burst_addr <= frame_base + offset;
        last_burst    <= last_nxt;
      end
      if ((state == S_BURST) && wr_burst_finish) begin
        if (off_end > {1'b0, FRAME_SIZE}) begin
          offset        <= 24'd0;
          frame_overrun <= 1'b1;
        end else begin
          offset <= off_sum;
        end
      end
      if (state == S_SWAP) begin
        done_frame_idx <= wr_frame_idx;
        wr_frame_idx   <= swap_idx;
        offset         <= 24'd0;
      end
      // A start landing on the SWAP cycle belongs to the next frame, so set wins over clear.
      if (frame_start)           pend_start <= 1'b1;
      else if (state == S_SWAP)  pend_start <= 1'b0;
    end
  end

`ifdef FRAME_WR_STAT_EN
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      frame_words <= 24'd0;
      burst_cnt   <= 16'd0;
    end else begin
      if (state == S_SWAP) frame_words <= offset;
      if (load_req && (burst_cnt != 16'hFFFF)) burst_cnt <= burst_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_write_ctrl.sv
// tb/tb_frame_write_ctrl.sv - randomized self-checking bench for frame_write_ctrl
module tb_frame_write_ctrl;
  localparam int          BL   = 16;
  localparam logic [23:0] FS   = 24'h000040;
  localparam logic [23:0] BASE = 24'h001000;

  logic        mem_clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [1:0]  rd_lock_idx = 2'd0;
  logic [10:0] fifo_rd_count = 11'd0;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = 32'd0;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [23:0] wr_burst_addr;
  logic        wr_burst_data_req = 1'b0;
  logic [31:0] wr_burst_data;
  logic        wr_burst_finish = 1'b0;
  logic [1:0]  wr_frame_idx;
  logic [1:0]  done_frame_idx;
  logic        frame_done;
  logic        frame_overrun;

  int n_pass = 0;
  int n_total = 0;
  int m_wr, m_done, m_off, m_ovr, exp_word;
  int fifo_next = 0;

  frame_write_ctrl #(
    .MEM_DATA_BITS(32), .BURST_LEN(BL), .BASE_ADDR(BASE), .FRAME_SIZE(FS)
  ) dut (
    .mem_clk(mem_clk), .rst(rst), .frame_start(frame_start), .rd_lock_idx(rd_lock_idx),
    .fifo_rd_count(fifo_rd_count), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
    .wr_burst_finish(wr_burst_finish), .wr_frame_idx(wr_frame_idx),
    .done_frame_idx(done_frame_idx), .frame_done(frame_done), .frame_overrun(frame_overrun)
  );

  always #5 mem_clk = ~mem_clk;

  function automatic logic [31:0] word_of(input int n);
    return (n * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Pixel FIFO: popped word appears one cycle after fifo_rd_en.
  always @(posedge mem_clk) begin
    if (fifo_rd_en === 1'b1) begin
      fifo_rd_data <= word_of(fifo_next);
      fifo_next    <= fifo_next + 1;
    end
  end

  function automatic int next_idx(input int wr, input int rd);
    if (rd == wr) return (wr + 1) % 3;
    for (int k = 0; k < 3; k++) if (k != wr && k != rd) return k;
    return 0;
  endfunction

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic model_reset();
    m_wr = 0; m_done = 2; m_off = 0; m_ovr = 0;
  endtask

  task automatic do_burst(input int len, input int next_count, input int start_mode, output bit ok);
    int exp_addr, w, sent, pulses;
    bit prev, started;
    exp_addr = (int'(BASE) + m_wr * int'(FS) + m_off) % (1 << 24);
    ok = 1'b0;
    w = 0;
    while (wr_burst_req !== 1'b1 && w < 400) begin tick(); w++; end
    n_total++;
    if (wr_burst_req !== 1'b1) begin
      $display("FAIL burst_req_timeout: req=%b after %0d cycles, required 1", wr_burst_req, w);
      return;
    end
    n_pass++;
    n_total++;
    if (wr_burst_addr !== 24'(exp_addr)) $display("FAIL burst_addr: got %h required %h", wr_burst_addr, 24'(exp_addr));
    else n_pass++;
    n_total++;
    if (wr_burst_len !== 10'(len)) $display("FAIL burst_len: got %0d required %0d", wr_burst_len, len);
    else n_pass++;
    fifo_rd_count = 11'd0;
    sent = 0; pulses = 0; prev = 1'b0; started = 1'b0;
    while (sent < len || prev) begin
      wr_burst_data_req = (sent < len) && (sent == 0 || $urandom_range(0, 3) != 0);
      frame_start = 1'b0;
      if (start_mode == 1 && !started && sent == len / 2) begin
        frame_start = 1'b1;
        started = 1'b1;
      end
      #1;
      if (fifo_rd_en === 1'b1) pulses++;
      if (prev) begin
        n_total++;
        if (wr_burst_data !== word_of(exp_word))
          $display("FAIL burst_data: word %0d got %h required %h", exp_word, wr_burst_data, word_of(exp_word));
        else n_pass++;
        exp_word++;
      end
      prev = wr_burst_data_req;
      if (wr_burst_data_req) sent++;
      tick();
    end
    wr_burst_data_req = 1'b0;
    frame_start = 1'b0;
    n_total++;
    if (pulses != len) $display("FAIL rd_en_pulses: got %0d required %0d", pulses, len);
    else n_pass++;
    n_total++;
    if (wr_burst_req !== 1'b0) $display("FAIL req_drop: got %b required 0", wr_burst_req);
    else n_pass++;
    fifo_rd_count = 11'(next_count);
    wr_burst_finish = 1'b1;
    frame_start = (start_mode == 2);
    tick();
    wr_burst_finish = 1'b0;
    frame_start = 1'b0;
    m_off += len;
    if (m_off + len > int'(FS)) begin m_off = 0; m_ovr = 1; end
    ok = 1'b1;
  endtask

  // start_at < 0: start while idle after the full bursts; otherwise during full burst start_at.
  task automatic run_frame(input int nfull, input int flush_len, input int rd,
                           input int start_at, input int smode, input bit dbl);
    bit ok;
    int nc, w;
    rd_lock_idx = 2'(rd);
    if (nfull > 0) fifo_rd_count = 11'(BL);
    for (int i = 0; i < nfull; i++) begin
      if (i < nfull - 1) nc = BL;
      else if (start_at >= 0) nc = flush_len;
      else nc = 0;
      do_burst(BL, nc, (i == start_at) ? smode : 0, ok);
      if (!ok) return;
    end
    if (start_at < 0) begin
      fifo_rd_count = 11'(flush_len);
      tick(); tick();
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      if (dbl) begin tick(); frame_start = 1'b1; tick(); frame_start = 1'b0; end
    end
    if (flush_len > 0) begin
      do_burst(flush_len, 0, 0, ok);
      if (!ok) return;
    end
    m_done = m_wr;
    m_wr = next_idx(m_wr, rd);
    m_off = 0;
    w = 0;
    while (frame_done !== 1'b1 && w < 40) begin tick(); w++; end
    n_total++;
    if (frame_done !== 1'b1) begin
      $display("FAIL frame_done_timeout: frame_done=%b after %0d cycles, required 1", frame_done, w);
      return;
    end
    n_pass++;
    n_total++;
    if (done_frame_idx !== 2'(m_done)) $display("FAIL done_idx: got %0d required %0d", done_frame_idx, m_done);
    else n_pass++;
    n_total++;
    if (wr_frame_idx !== 2'(m_wr)) $display("FAIL wr_idx: got %0d required %0d", wr_frame_idx, m_wr);
    else n_pass++;
    n_total++;
    if (frame_overrun !== 1'(m_ovr)) $display("FAIL overrun: got %b required %0d", frame_overrun, m_ovr);
    else n_pass++;
    tick();
    n_total++;
    if (frame_done !== 1'b0) $display("FAIL frame_done_pulse: got %b required 0", frame_done);
    else n_pass++;
  endtask

  task automatic check_reset_values(input string tag);
    n_total++;
    if (wr_burst_req !== 1'b0) $display("FAIL %s_req: got %b required 0", tag, wr_burst_req); else n_pass++;
    n_total++;
    if (wr_burst_len !== 10'd0) $display("FAIL %s_len: got %0d required 0", tag, wr_burst_len); else n_pass++;
    n_total++;
    if (wr_burst_addr !== BASE) $display("FAIL %s_addr: got %h required %h", tag, wr_burst_addr, BASE); else n_pass++;
    n_total++;
    if (fifo_rd_en !== 1'b0) $display("FAIL %s_rd_en: got %b required 0", tag, fifo_rd_en); else n_pass++;
    n_total++;
    if (frame_done !== 1'b0) $display("FAIL %s_frame_done: got %b required 0", tag, frame_done); else n_pass++;
    n_total++;
    if (frame_overrun !== 1'b0) $display("FAIL %s_overrun: got %b required 0", tag, frame_overrun); else n_pass++;
    n_total++;
    if (wr_frame_idx !== 2'd0) $display("FAIL %s_wr_idx: got %0d required 0", tag, wr_frame_idx); else n_pass++;
    n_total++;
    if (done_frame_idx !== 2'd2) $display("FAIL %s_done_idx: got %0d required 2", tag, done_frame_idx); else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    model_reset();
    exp_word = fifo_next;
    tick();
  endtask

  task automatic test_full_bursts();
    run_frame(3, 5, 2, -1, 0, 1'b0);
  endtask

  task automatic test_overrun();
    run_frame(5, 0, 0, -1, 0, 1'b0);
    n_total++;
    if (frame_overrun !== 1'b1) $display("FAIL overrun_sticky: got %b required 1", frame_overrun);
    else n_pass++;
  endtask

  task automatic test_swap_rules();
    run_frame(1, 3, 0, -1, 0, 1'b0);
    run_frame(1, 3, 2, -1, 0, 1'b0);
    n_total++;
    if (wr_frame_idx !== 2'd0) $display("FAIL swap_lock2_from1: got %0d required 0", wr_frame_idx);
    else n_pass++;
    run_frame(1, 0, 2, -1, 0, 1'b1);
    run_frame(1, 4, 1, -1, 0, 1'b0);
    n_total++;
    if (wr_frame_idx !== 2'd2) $display("FAIL swap_lock1_from1: got %0d required 2", wr_frame_idx);
    else n_pass++;
  endtask

  task automatic test_start_mid_burst();
    run_frame(3, 7, 0, 1, 1, 1'b0);
  endtask

  task automatic test_start_with_finish();
    run_frame(2, 6, 1, 1, 2, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    int w;
    rd_lock_idx = 2'd0;
    fifo_rd_count = 11'(BL);
    w = 0;
    while (wr_burst_req !== 1'b1 && w < 100) begin tick(); w++; end
    n_total++;
    if (wr_burst_req !== 1'b1) $display("FAIL rst_burst_req_timeout: req=%b required 1", wr_burst_req);
    else n_pass++;
    repeat (4) begin wr_burst_data_req = 1'b1; tick(); end
    rst = 1'b1;
    tick();
    check_reset_values("midburst_reset");
    rst = 1'b0;
    wr_burst_data_req = 1'b0;
    exp_word = fifo_next;
    model_reset();
    run_frame(1, 0, 1, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int nfull, flush_len, rd, start_at;
    for (int f = 0; f < 12; f++) begin
      nfull     = $urandom_range(0, 5);
      flush_len = $urandom_range(0, BL - 1);
      rd        = $urandom_range(0, 2);
      start_at  = (nfull == 0) ? -1 : int'($urandom_range(0, nfull)) - 1;
      run_frame(nfull, flush_len, rd, start_at, $urandom_range(1, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_bursts();
    test_overrun();
    test_swap_rules();
    test_start_mid_burst();
    test_start_with_finish();
    test_reset_mid_burst();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
